// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP word,
// instruction field positions and the PC increment helper.
package if_id_stage_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Sequential PC; the add wraps naturally modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry data+valid register that parks a fetched word while the
// pipeline is stalled. Clear wins over load.
module if_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Capture on load, drop on clear, otherwise keep the parked word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Fetches at PC,
// parks a returned word in a skid buffer when the pipeline stalls, and
// redirects/flushes on a taken branch.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Branch,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic [4:0]  IF_ID_RsAddr,
  output logic [4:0]  IF_ID_RtAddr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         stall;
  logic [31:0]  pc_plus4;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_data;
  logic         skid_valid;

  assign stall    = IF_ID_Write | ~PCWrite;
  assign pc_plus4 = next_pc(pc_q);

  if_skid_buffer #(
    .WIDTH(32)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .data      (skid_data),
    .valid     (skid_valid)
  );

  // State, PC and IF/ID register; everything returns to its reset value at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: branch flush beats stall, stall beats normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (Branch) begin
      pc_d       = BranchAddr;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d    = skid_data;
            pc4_d      = pc_plus4;
            valid_d    = skid_valid;
            pc_d       = pc_plus4;
            skid_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Request only from FETCH, and never while reset is held.
  assign imem_req  = (state_q == FETCH) && !rst;
  assign imem_addr = pc_q;

  assign PC           = pc_q;
  assign IF_ID_PC4    = pc4_q;
  assign IF_ID_Instr  = instr_q;
  assign IF_ID_Valid  = valid_q;
  assign IF_ID_RsAddr = instr_q[RS_MSB:RS_LSB];
  assign IF_ID_RtAddr = instr_q[RT_MSB:RT_LSB];

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word placed in IF/ID on reset or flush.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 PCWrite  in  1  from hazard detection; 1 = PC may advance.
REQ-006 IF_ID_Write  in  1  from hazard detection; 1 = hold IF/ID contents (stall), 0 = normal update.
REQ-007 Branch  in  1  taken branch/jump resolved in ID; redirect fetch and flush.
REQ-008 BranchAddr  in  32  redirect target, word-aligned.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 imem_addr  out  32  fetch address (= PC).
REQ-011 imem_ready  in  1  fetch data valid this cycle; zero or more wait cycles allowed.
REQ-012 imem_rdata  in  32  fetched instruction.
REQ-013 PC  out  32  current fetch PC.
REQ-014 IF_ID_PC4  out  32  PC+4 of instruction held in IF/ID.
REQ-015 IF_ID_Instr  out  32  instruction held in IF/ID.
REQ-016 IF_ID_Valid  out  1  IF/ID holds a real instruction.
REQ-017 IF_ID_RsAddr  out  5  IF_ID_Instr[25:21], combinational from register.
REQ-018 IF_ID_RtAddr  out  5  IF_ID_Instr[20:16], combinational from register.

Function
REQ-019 Stall condition stall = IF_ID_Write | ~PCWrite.
REQ-020 FSM states FETCH, HOLD; FETCH entered from reset.
REQ-021 FETCH: imem_req=1, imem_addr=PC; imem_addr stable while imem_req=1 and imem_ready=0.
REQ-022 FETCH, imem_ready=1, no stall, no Branch: IF_ID_Instr<=imem_rdata, IF_ID_PC4<=PC+4, IF_ID_Valid<=1, PC<=PC+4, stay FETCH.
REQ-023 FETCH, imem_ready=0, no Branch: IF/ID loads NOP_INSTR with Valid=0 unless stall (then hold); PC holds.
REQ-024 FETCH, imem_ready=1, stall, no Branch: imem_rdata captured into 1-entry skid buffer, IF/ID and PC hold, go HOLD.
REQ-025 HOLD: imem_req=0; IF/ID and PC hold while stall=1.
REQ-026 HOLD, stall=0: IF/ID loads skid buffer (Valid=1, PC4=PC+4), PC<=PC+4, go FETCH.
REQ-027 Branch=1 (any state, regardless of stall): PC<=BranchAddr, IF_ID_Instr<=NOP_INSTR, IF_ID_Valid<=0, skid buffer discarded, any imem_rdata that cycle discarded, go FETCH.
REQ-028 Priority: rst > Branch > stall > normal fetch.
REQ-029 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no overflow flag.
REQ-030 Throughput one instruction per cycle with zero-wait memory; IF/ID latency one cycle from imem_ready.
REQ-031 Exactly one instruction accepted per PC value; no instruction dropped or duplicated across stalls.

Reset
REQ-032 On rst: PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_Valid=0, skid buffer empty, state=FETCH.
REQ-033 rst mid-fetch or in HOLD abandons the fetch; imem_req low while rst high, first request on first edge after release with imem_addr=RESET_PC.

Structure
REQ-034 Shared package holds FSM state encoding, NOP encoding, instruction field bit positions (RS 25:21, RT 20:16).
REQ-035 One sub-module natural: if_skid_buffer (1-entry data+valid register with load/clear).
REQ-036 No combinational path from imem_rdata to PC or imem_addr.

Verification
REQ-037 Zero-wait stream from RESET_PC=0, rdata=PC-derived -> IF/ID shows 4 sequential instrs, PC4=4,8,12,16, Valid=1 each cycle.
REQ-038 Load-use stall: IF_ID_Write=1, PCWrite=0 for 1 cycle at PC=8 with ready=1 -> IF/ID holds PC4=8 instr, next cycle shows PC=8 instr, no loss or duplicate.
REQ-039 Branch=1, BranchAddr=32'h40 during stall in HOLD -> next edge PC=32'h40, IF_ID_Valid=0, Instr=NOP, buffer discarded, next fetch addr 32'h40.
REQ-040 imem_ready low 3 cycles at PC=12 -> imem_addr stays 12, IF_ID_Valid=0 bubbles, PC advances once on ready.
REQ-041 PC=32'hFFFF_FFFC, ready=1 -> PC=0, IF_ID_PC4=0.
REQ-042 rst asserted mid-wait between edges -> outputs immediately at reset values, first fetch after release at RESET_PC.
